// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - key codes, sequencer states and digit decode for rpn_key_sequencer
package rpn_pkg;

  // Numpad codes as delivered by the scanner (bit4 = key held)
  localparam logic [4:0] KEY_1    = 5'b10000;
  localparam logic [4:0] KEY_4    = 5'b10001;
  localparam logic [4:0] KEY_7    = 5'b10010;
  localparam logic [4:0] KEY_0    = 5'b10011;
  localparam logic [4:0] KEY_2    = 5'b10100;
  localparam logic [4:0] KEY_5    = 5'b10101;
  localparam logic [4:0] KEY_8    = 5'b10110;
  localparam logic [4:0] KEY_CLR  = 5'b10111;
  localparam logic [4:0] KEY_3    = 5'b11000;
  localparam logic [4:0] KEY_6    = 5'b11001;
  localparam logic [4:0] KEY_9    = 5'b11010;
  localparam logic [4:0] KEY_DIV  = 5'b11011;
  localparam logic [4:0] KEY_PUSH = 5'b11100;
  localparam logic [4:0] KEY_ADD  = 5'b11101;
  localparam logic [4:0] KEY_SUB  = 5'b11110;
  localparam logic [4:0] KEY_MUL  = 5'b11111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } rpn_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } digit_t;

  // Map a key code to its digit value; valid is low for non-digit keys
  function automatic digit_t decode_digit(input logic [4:0] code);
    digit_t d;
    d.valid = 1'b1;
    d.value = 4'd0;
    case (code)
      KEY_0:   d.value = 4'd0;
      KEY_1:   d.value = 4'd1;
      KEY_2:   d.value = 4'd2;
      KEY_3:   d.value = 4'd3;
      KEY_4:   d.value = 4'd4;
      KEY_5:   d.value = 4'd5;
      KEY_6:   d.value = 4'd6;
      KEY_7:   d.value = 4'd7;
      KEY_8:   d.value = 4'd8;
      KEY_9:   d.value = 4'd9;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring unsigned divider, one quotient bit per cycle
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_rem_in;
  logic [WIDTH-1:0] w_quo_in;
  logic [WIDTH-1:0] w_dvs_in;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_sub;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  // One restoring step; the start cycle already performs the first step so
  // the quotient is complete WIDTH cycles after start
  always_comb begin
    w_rem_in = start ? '0 : r_rem;
    w_quo_in = start ? dividend : r_quo;
    w_dvs_in = start ? divisor : r_dvs;
    w_trial  = {w_rem_in, w_quo_in[WIDTH-1]};
    w_fits   = (w_trial >= {1'b0, w_dvs_in});
    // When the trial fits, trial - divisor < divisor, so the low bits are exact
    w_sub    = w_trial[WIDTH-1:0] - w_dvs_in;
    w_rem_nx = w_fits ? w_sub : w_trial[WIDTH-1:0];
    w_quo_nx = {w_quo_in[WIDTH-2:0], w_fits};
  end

  // Iteration counter and partial remainder/quotient registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (start) begin
      r_rem  <= w_rem_nx;
      r_quo  <= w_quo_nx;
      r_dvs  <= divisor;
      r_cnt  <= CW'(WIDTH - 1);
      r_done <= (WIDTH == 1);
    end else if (r_cnt != '0) begin
      r_rem  <= w_rem_nx;
      r_quo  <= w_quo_nx;
      r_cnt  <= r_cnt - 1'b1;
      r_done <= (r_cnt == CW'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/rpn_key_sequencer.sv
// rtl/rpn_key_sequencer.sv - numpad code to operand-stack command sequencer
module rpn_key_sequencer
  import rpn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       key,
  input  logic             hex_mode,
  input  logic [WIDTH-1:0] top,
  input  logic [WIDTH-1:0] next,
  input  logic [CNT_W-1:0] count,
  output logic             push,
  output logic             pop,
  output logic             write,
  output logic [WIDTH-1:0] new_value,
  output logic             busy,
  output logic             overflow,
  output logic             op_error,
  input  logic             clear_flags
);

  logic [4:0]       r_key;
  rpn_state_e       r_state;
  logic             r_push;
  logic             r_pop;
  logic             r_write;
  logic [WIDTH-1:0] r_value;
  logic             r_ovf;
  logic             r_err;

  logic             w_event;
  digit_t           w_digit;
  logic             w_few;
  logic [2*WIDTH-1:0] w_radix;
  logic [2*WIDTH-1:0] w_wide;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  rpn_state_e       w_state_nx;
  logic             w_push;
  logic             w_pop;
  logic             w_write;
  logic [WIDTH-1:0] w_value;
  logic             w_set_ovf;
  logic             w_set_err;
  logic             w_start;
  logic             w_div_done;
  logic [WIDTH-1:0] w_quotient;
  logic [WIDTH-1:0] w_rem_unused;

  // A press is the rising edge of the held bit; code changes while held are not presses
  assign w_event = key[4] & ~r_key[4];
  assign w_digit = decode_digit(key);
  assign w_few   = (count < CNT_W'(2));

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (w_start),
    .dividend  (next),
    .divisor   (top),
    .done      (w_div_done),
    .quotient  (w_quotient),
    .remainder (w_rem_unused)
  );

  // Decode the press into next-cycle commands, flag sets and FSM transition
  always_comb begin
    w_state_nx = r_state;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_write    = 1'b0;
    w_value    = r_value;
    w_set_ovf  = 1'b0;
    w_set_err  = 1'b0;
    w_start    = 1'b0;
    w_radix    = hex_mode ? (2*WIDTH)'(16) : (2*WIDTH)'(10);
    w_wide     = ({{WIDTH{1'b0}}, top} * w_radix) + (2*WIDTH)'(w_digit.value);
    w_prod     = {{WIDTH{1'b0}}, next} * {{WIDTH{1'b0}}, top};
    w_sum      = {1'b0, next} + {1'b0, top};
    w_diff     = {1'b0, next} - {1'b0, top};
    case (r_state)
      IDLE: begin
        if (w_event) begin
          if (w_digit.valid) begin
            if (w_wide[2*WIDTH-1:WIDTH] == '0) begin
              w_write = 1'b1;
              w_value = w_wide[WIDTH-1:0];
            end else begin
              w_set_ovf = 1'b1;
            end
          end else begin
            case (key)
              KEY_CLR: begin
                w_write = 1'b1;
                w_value = '0;
              end
              KEY_PUSH: w_push = 1'b1;
              KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV: begin
                if (w_few) begin
                  w_set_err = 1'b1;
                end else if (key == KEY_ADD) begin
                  w_pop     = 1'b1;
                  w_write   = 1'b1;
                  w_value   = w_sum[WIDTH-1:0];
                  w_set_ovf = w_sum[WIDTH];
                end else if (key == KEY_SUB) begin
                  w_pop     = 1'b1;
                  w_write   = 1'b1;
                  w_value   = w_diff[WIDTH-1:0];
                  w_set_ovf = w_diff[WIDTH];
                end else if (key == KEY_MUL) begin
                  w_pop     = 1'b1;
                  w_write   = 1'b1;
                  w_value   = w_prod[WIDTH-1:0];
                  w_set_ovf = (w_prod[2*WIDTH-1:WIDTH] != '0);
                end else if (top == '0) begin
                  w_set_err = 1'b1;
                end else begin
                  w_start    = 1'b1;
                  w_state_nx = DIV;
                end
              end
              default: ;
            endcase
          end
        end
      end
      DIV: begin
        // Presses during the divide are dropped, not queued
        if (w_div_done) begin
          w_state_nx = DONE;
          w_pop      = 1'b1;
          w_write    = 1'b1;
          w_value    = w_quotient;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Register commands and sticky flags; clear_flags wins over a same-cycle set
  always_ff @(posedge clock) begin
    if (reset) begin
      r_key   <= '0;
      r_state <= IDLE;
      r_push  <= 1'b0;
      r_pop   <= 1'b0;
      r_write <= 1'b0;
      r_value <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_key   <= key;
      r_state <= w_state_nx;
      r_push  <= w_push;
      r_pop   <= w_pop;
      r_write <= w_write;
      r_value <= w_value;
      r_ovf   <= clear_flags ? 1'b0 : (r_ovf | w_set_ovf);
      r_err   <= clear_flags ? 1'b0 : (r_err | w_set_err);
    end
  end

  assign push      = r_push;
  assign pop       = r_pop;
  assign write     = r_write;
  assign new_value = r_value;
  assign busy      = (r_state == DIV);
  assign overflow  = r_ovf;
  assign op_error  = r_err;

endmodule

// File: tb/tb_rpn_key_sequencer.sv
// tb/tb_rpn_key_sequencer.sv - randomized model-checked bench for rpn_key_sequencer
module tb_rpn_key_sequencer;

  localparam int W     = 32;
  localparam int CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [4:0]       key = '0;
  logic             hex_mode = 1'b0;
  logic [W-1:0]     top = '0;
  logic [W-1:0]     next = '0;
  logic [CNT_W-1:0] count = '0;
  logic             clear_flags = 1'b0;
  logic             push;
  logic             pop;
  logic             write;
  logic [W-1:0]     new_value;
  logic             busy;
  logic             overflow;
  logic             op_error;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit exp_ovf = 1'b0;
  bit exp_err = 1'b0;

  rpn_key_sequencer #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .key         (key),
    .hex_mode    (hex_mode),
    .top         (top),
    .next        (next),
    .count       (count),
    .push        (push),
    .pop         (pop),
    .write       (write),
    .new_value   (new_value),
    .busy        (busy),
    .overflow    (overflow),
    .op_error    (op_error),
    .clear_flags (clear_flags)
  );

  always #10 clock = ~clock;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int digit_of(input logic [4:0] c);
    case (c)
      5'b10000: return 1;
      5'b10001: return 4;
      5'b10010: return 7;
      5'b10011: return 0;
      5'b10100: return 2;
      5'b10101: return 5;
      5'b10110: return 8;
      5'b11000: return 3;
      5'b11001: return 6;
      5'b11010: return 9;
      default:  return -1;
    endcase
  endfunction

  // Calculator semantics of a single press, in plain 64-bit arithmetic
  task automatic model(input logic [4:0] c, input bit hex, input logic [31:0] t, input logic [31:0] nx,
                       input int cnt, output bit e_push, output bit e_pop, output bit e_write,
                       output logic [31:0] e_val, output bit e_ovf, output bit e_err, output bit e_div);
    longint unsigned wide;
    int d;
    e_push = 0; e_pop = 0; e_write = 0; e_val = '0; e_ovf = 0; e_err = 0; e_div = 0;
    d = digit_of(c);
    if (d >= 0) begin
      wide = 64'(t) * (hex ? 64'd16 : 64'd10) + 64'(d);
      if (wide < 64'h1_0000_0000) begin
        e_write = 1;
        e_val   = wide[31:0];
      end else begin
        e_ovf = 1;
      end
    end else if (c == 5'b10111) begin
      e_write = 1;
    end else if (c == 5'b11100) begin
      e_push = 1;
    end else if (cnt < 2) begin
      e_err = 1;
    end else if (c == 5'b11101) begin
      wide = 64'(nx) + 64'(t);
      e_pop = 1; e_write = 1; e_val = wide[31:0]; e_ovf = (wide > 64'hFFFF_FFFF);
    end else if (c == 5'b11110) begin
      e_pop = 1; e_write = 1; e_val = nx - t; e_ovf = (nx < t);
    end else if (c == 5'b11111) begin
      wide = 64'(nx) * 64'(t);
      e_pop = 1; e_write = 1; e_val = wide[31:0]; e_ovf = ((wide >> 32) != 0);
    end else if (t == 0) begin
      e_err = 1;
    end else begin
      e_div = 1; e_pop = 1; e_write = 1; e_val = nx / t;
    end
  endtask

  // Apply one press, watch a window of cycles and compare against the model
  task automatic run_press(input string tag, input logic [4:0] c, input bit hex, input logic [31:0] t,
                           input logic [31:0] nx, input int cnt, input int hold, input bit clr_with,
                           input int inject_at);
    bit e_push, e_pop, e_write, e_ovf, e_err, e_div;
    logic [31:0] e_val;
    logic [31:0] last_val;
    int window, exp_idx;
    int n_push, n_pop, n_write, n_busy, i_push, i_pop, i_write;
    model(c, hex, t, nx, cnt, e_push, e_pop, e_write, e_val, e_ovf, e_err, e_div);
    window = e_div ? W + 4 : 0;
    if (window < hold + 4) window = hold + 4;
    n_push = 0; n_pop = 0; n_write = 0; n_busy = 0;
    i_push = -1; i_pop = -1; i_write = -1; last_val = '0;
    @(negedge clock);
    hex_mode = hex; top = t; next = nx; count = CNT_W'(cnt);
    key = c; clear_flags = clr_with;
    for (int i = 0; i < window; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (i == 0) clear_flags = 1'b0;
      if (push)  begin n_push++;  if (i_push < 0)  i_push = i;  end
      if (pop)   begin n_pop++;   if (i_pop < 0)   i_pop = i;   end
      if (write) begin n_write++; if (i_write < 0) i_write = i; last_val = new_value; end
      if (busy) n_busy++;
      if (i == hold - 1) key = '0;
      if (inject_at >= 0 && i == inject_at) key = 5'b11000;
      if (inject_at >= 0 && i == inject_at + 2) key = '0;
    end
    if (clr_with) begin
      exp_ovf = 0;
      exp_err = 0;
    end else begin
      exp_ovf = exp_ovf | e_ovf;
      exp_err = exp_err | e_err;
    end
    exp_idx = e_div ? W : 0;
    check_val({tag, ".push_n"},  64'(n_push),  64'(e_push ? 1 : 0));
    check_val({tag, ".pop_n"},   64'(n_pop),   64'(e_pop ? 1 : 0));
    check_val({tag, ".write_n"}, 64'(n_write), 64'(e_write ? 1 : 0));
    check_val({tag, ".push_at"}, 64'(i_push),  64'(e_push ? exp_idx : -1));
    check_val({tag, ".pop_at"},  64'(i_pop),   64'(e_pop ? exp_idx : -1));
    check_val({tag, ".write_at"}, 64'(i_write), 64'(e_write ? exp_idx : -1));
    if (e_write) check_val({tag, ".value"}, 64'(last_val), 64'(e_val));
    check_val({tag, ".busy_n"},   64'(n_busy),   64'(e_div ? W : 0));
    check_val({tag, ".overflow"}, 64'(overflow), 64'(exp_ovf));
    check_val({tag, ".op_error"}, 64'(op_error), 64'(exp_err));
  endtask

  task automatic do_clear(input string tag);
    @(negedge clock);
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
    exp_ovf = 0;
    exp_err = 0;
    check_val({tag, ".overflow"}, 64'(overflow), 64'(exp_ovf));
    check_val({tag, ".op_error"}, 64'(op_error), 64'(exp_err));
  endtask

  initial begin
    int n_write;
    logic [4:0]  rc;
    logic [31:0] rt, rn;
    int sel;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_val("rst.push",      64'(push),      64'd0);
    check_val("rst.pop",       64'(pop),       64'd0);
    check_val("rst.write",     64'(write),     64'd0);
    check_val("rst.new_value", 64'(new_value), 64'd0);
    check_val("rst.busy",      64'(busy),      64'd0);
    check_val("rst.overflow",  64'(overflow),  64'd0);
    check_val("rst.op_error",  64'(op_error),  64'd0);
    reset = 1'b0;

    run_press("dec1",   5'b10000, 0, 32'd0,          32'd0,          0, 1,   0, -1);
    run_press("dec7",   5'b10010, 0, 32'd12,         32'd0,          0, 100, 0, -1);
    run_press("hex5",   5'b10101, 1, 32'h0FFF_FFFF,  32'd0,          0, 2,   0, -1);
    run_press("hex3",   5'b11000, 1, 32'hFFFF_FFF5,  32'd0,          0, 2,   0, -1);
    do_clear("clr1");
    run_press("addc",   5'b11101, 0, 32'd2,          32'hFFFF_FFFF,  2, 1,   0, -1);
    do_clear("clr2");
    run_press("mulund", 5'b11111, 0, 32'd5,          32'd6,          1, 1,   0, -1);
    do_clear("clr3");
    run_press("div",    5'b11011, 0, 32'd7,          32'd100,        2, 2,   0, 5);
    run_press("div0",   5'b11011, 0, 32'd0,          32'd100,        2, 2,   0, -1);
    run_press("clrpri", 5'b11101, 0, 32'd2,          32'hFFFF_FFFF,  2, 1,   1, -1);
    run_press("clrent", 5'b10111, 1, 32'd1234,       32'd0,          0, 1,   0, -1);
    run_press("sub",    5'b11110, 0, 32'd9,          32'd4,          3, 1,   0, -1);

    // Reset in the tenth cycle of a divide aborts it with no command
    @(negedge clock);
    top = 32'd7; next = 32'd100; count = CNT_W'(2); key = 5'b11011;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (i == 1) key = '0;
    end
    reset = 1'b1;
    @(negedge clock);
    check_val("rstdiv.busy",      64'(busy),      64'd0);
    check_val("rstdiv.write",     64'(write),     64'd0);
    check_val("rstdiv.pop",       64'(pop),       64'd0);
    check_val("rstdiv.new_value", 64'(new_value), 64'd0);
    check_val("rstdiv.flags",     64'({overflow, op_error}), 64'd0);
    reset = 1'b0;
    exp_ovf = 0;
    exp_err = 0;
    n_write = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clock);
      if (write || pop) n_write++;
    end
    check_val("rstdiv.nocmd", 64'(n_write), 64'd0);
    run_press("postpush", 5'b11100, 0, 32'd3, 32'd0, 1, 1, 0, -1);

    for (int n = 0; n < 150; n++) begin
      rc  = {1'b1, 4'($urandom_range(0, 15))};
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rt = $urandom;
        1:       rt = $urandom_range(0, 1000);
        2:       rt = $urandom_range(0, 32'h1999_999A);
        default: rt = $urandom_range(0, 3);
      endcase
      rn = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 5000);
      run_press("rnd", rc, 1'($urandom_range(0, 1)), rt, rn, $urandom_range(0, 4),
                $urandom_range(1, 5), ($urandom_range(0, 9) == 0), -1);
      if ($urandom_range(0, 7) == 0) do_clear("rndclr");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rpn_key_sequencer.md
Name: rpn_key_sequencer

Overview:
- Parametrised successor to the calculator's key-to-stack command logic.
- Converts 5-bit numpad codes into single-cycle push/pop/write commands for the operand stack.
- Adds per-press edge detection, a decimal/hex entry mode, entry-overflow rejection, operand-underflow checks, a multi-cycle unsigned divide, and sticky status flags.
- Sits between the numpad scanner and the stack; display_bcd consumes its flags.

Parameters:
- WIDTH, 32: operand/result width in bits.
- CNT_W, 6: width of the stack element count input.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- key  in  5  numpad code; bit4=1 means a key is held, bits3:0 select the key
- hex_mode  in  1  0 = decimal entry (radix 10), 1 = hex entry (radix 16); sampled at each digit press
- top  in  WIDTH  stack element 0
- next  in  WIDTH  stack element 1
- count  in  CNT_W  stack element count
- push  out  1  one-cycle pulse: duplicate/push top
- pop  out  1  one-cycle pulse: drop top
- write  out  1  one-cycle pulse: write new_value into top (after pop, if both set)
- new_value  out  WIDTH  value accompanying write
- busy  out  1  high while a divide is in progress
- overflow  out  1  sticky: result or entry exceeded WIDTH bits
- op_error  out  1  sticky: operator rejected (count<2 or divide by zero)
- clear_flags  in  1  synchronous clear of overflow and op_error

Behaviour:
- Reset: push=pop=write=0, new_value=0, busy=0, overflow=0, op_error=0, FSM=IDLE, key register=0.
- key is registered once. An event is a rising transition of bit4 (prev bit4=0, now 1). A held key produces exactly one event. A code change while bit4 stays high is not an event.
- Command pulses assert in the cycle after the event cycle and last exactly one cycle. All other cycles hold push/pop/write at 0.
- Digit codes map as follows: 10000=1, 10001=4, 10010=7, 10011=0, 10100=2, 10101=5, 10110=8, 11000=3, 11001=6, 11010=9.
- Digit entry:
  - Compute wide = top*R + d at 2*WIDTH precision.
  - If wide < 2^WIDTH: write=1, new_value=wide.
  - Otherwise: no write, overflow is set.
- 10111 (*): clear entry, write=1, new_value=0.
- 11100 (A, =): push=1.
- Binary operators (B, C, D, #) with count<2: no command issued, op_error is set.
- 11101 (B, +): pop=1, write=1, new_value=next+top mod 2^WIDTH. overflow is set on carry out.
- 11110 (C, -): pop=1, write=1, new_value=next-top mod 2^WIDTH. overflow is set on borrow (next<top).
- 11111 (D, *): pop=1, write=1, new_value=low WIDTH bits of next*top. overflow is set if the high half is nonzero.
- 11011 (#, /): unsigned next/top.
  - top==0: no command, op_error is set.
  - Otherwise FSM goes IDLE->DIV with busy=1. The divider is started with next, top.
  - Completion comes exactly WIDTH cycles after start. Then FSM goes DIV->DONE with pop=1, write=1, new_value=quotient for one cycle, then DONE->IDLE.
  - busy deasserts in the DONE cycle.
- While busy, events are discarded. They are not queued.
- A press already held when DIV exits produces no event until it is released and pressed again.
- Any other code with bit4=1 is ignored.
- clear_flags has priority over a same-cycle flag set: the flags clear.
- reset mid-divide: abort immediately, issue no command, all outputs go to their reset values.

Decomposition:
- Package rpn_pkg holds:
  - the key-code localparams (KEY_0..KEY_9, KEY_PUSH, KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_CLR);
  - the FSM state enum (IDLE, DIV, DONE);
  - the digit-decode function (code -> 4-bit value, valid flag).
- Sub-module seq_divider, parametrised on WIDTH:
  - restoring divider, one quotient bit per cycle;
  - ports: clock, reset, start, dividend, divisor, done, quotient, remainder.

Test Plan:
- Decimal entry, hex_mode=0, top=0: press 1 -> write pulse, new_value=1. With top=12, press 7 -> new_value=127. Hold 7 for 100 cycles -> exactly one write.
- Hex entry and overflow, hex_mode=1, WIDTH=32:
  - top=0x0FFFFFFF, press 5 -> new_value=0xFFFFFFF5.
  - top=0xFFFFFFF5, press 3 -> no write, overflow=1.
- Add with carry, next=0xFFFFFFFF, top=2, count=2, press B -> pop=write=1 same cycle, new_value=1, overflow=1. clear_flags -> overflow=0.
- Underflow, count=1, press D -> no pulses, op_error=1.
- Divide, next=100, top=7, press # -> busy high for WIDTH cycles.
  - A 3 pressed during busy is ignored.
  - Then pop=write=1, new_value=14.
  - With top=0 instead -> op_error=1, busy never asserts.
- Reset during DIV (cycle 10 of 32) -> next cycle busy=0, no write. A subsequent A press -> push.
